// File: rtl/if_icache_fetch_if.sv
// Refill bus between the fetch-stage cache and the instruction memory controller.
// The cache drives req/addr; memory answers with a one-cycle ack carrying data.
interface if_icache_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/if_icache_fetch.sv
// Instruction-fetch stage: direct-mapped I-cache with zero-latency hits, a
// demand/prefetch refill FSM, whole-cache invalidate and hit/miss counters.
module if_icache_fetch #(
  parameter int ADDR_W   = 32,
  parameter int INST_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int PREFETCH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic                inv_i,
  if_icache_fetch_if.master   mem,
  output logic [INST_W-1:0]   inst_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic                stall_if,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int DEPTH = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, FILL, PREF} state_t;

  state_t              state_reg, state_next;
  logic                mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic                drop_reg, drop_next;
  logic [31:0]         hit_cnt_reg, miss_cnt_reg;
  logic                miss_inc;

  logic [DEPTH-1:0]    valid_reg;
  logic [TAG_W-1:0]    tag_mem  [DEPTH];
  logic [INST_W-1:0]   data_mem [DEPTH];

  logic [INDEX_W-1:0]  pc_idx, nxt_idx, fill_idx;
  logic [TAG_W-1:0]    pc_tag, nxt_tag, fill_tag;
  logic [ADDR_W-1:0]   pc_aligned, nxt_addr;
  logic                hit, nxt_hit, ack_ok, wr_en, fwd;

  assign pc_idx     = pc_i[INDEX_W+1:2];
  assign pc_tag     = pc_i[ADDR_W-1:INDEX_W+2];
  assign pc_aligned = {pc_i[ADDR_W-1:2], 2'b00};
  assign nxt_addr   = mem_addr_reg + ADDR_W'(4);
  assign nxt_idx    = nxt_addr[INDEX_W+1:2];
  assign nxt_tag    = nxt_addr[ADDR_W-1:INDEX_W+2];
  assign fill_idx   = mem_addr_reg[INDEX_W+1:2];
  assign fill_tag   = mem_addr_reg[ADDR_W-1:INDEX_W+2];

  // Asynchronous-read lookups: demand port for pc_i, second port to decide whether to prefetch.
  assign hit     = valid_reg[pc_idx]  && (tag_mem[pc_idx]  == pc_tag);
  assign nxt_hit = valid_reg[nxt_idx] && (tag_mem[nxt_idx] == nxt_tag);

  // An ack only counts against an outstanding request; invalidate or drop suppresses it.
  assign ack_ok = mem.mem_ack && mem_req_reg;
  assign wr_en  = ack_ok && !drop_reg && !inv_i;
  assign fwd    = wr_en && (mem_addr_reg == pc_aligned);

  assign mem.mem_req  = mem_req_reg;
  assign mem.mem_addr = mem_addr_reg;
  assign hit_cnt      = hit_cnt_reg;
  assign miss_cnt     = miss_cnt_reg;

  always_comb begin
    inst_o   = '0;
    pc_o     = '0;
    stall_if = 1'b0;
    if (rst_n) begin
      if (hit) begin
        inst_o = data_mem[pc_idx];
        pc_o   = pc_i;
      end else if (fwd) begin
        inst_o = mem.mem_data;
        pc_o   = pc_i;
      end else begin
        stall_if = 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;
    miss_inc      = 1'b0;
    drop_next     = drop_reg;
    if (ack_ok)
      drop_next = 1'b0;
    else if (inv_i && mem_req_reg)
      drop_next = 1'b1;
    case (state_reg)
      IDLE: begin
        if (!hit) begin
          state_next    = FILL;
          mem_req_next  = 1'b1;
          mem_addr_next = pc_aligned;
          miss_inc      = 1'b1;
        end
      end
      FILL: begin
        if (ack_ok) begin
          mem_req_next = 1'b0;
          state_next   = IDLE;
          // A dropped or invalidated fill does not chain into a prefetch.
          if ((PREFETCH != 0) && wr_en && !nxt_hit) begin
            state_next    = PREF;
            mem_req_next  = 1'b1;
            mem_addr_next = nxt_addr;
          end
        end
      end
      PREF: begin
        if (ack_ok) begin
          mem_req_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      drop_reg     <= 1'b0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
      drop_reg     <= drop_next;
      hit_cnt_reg  <= hit_cnt_reg + 32'(hit);
      miss_cnt_reg <= miss_cnt_reg + 32'(miss_inc);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          valid_reg[gi] <= 1'b0;
        else if (inv_i)
          valid_reg[gi] <= 1'b0;
        else if (wr_en && (fill_idx == INDEX_W'(gi)))
          valid_reg[gi] <= 1'b1;
      end
    end
  endgenerate

  // Tag/data need no reset: a line is only ever read when its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem.mem_data;
    end
  end
endmodule

// File: tb/tb_if_icache_fetch.sv
// Directed bench for if_icache_fetch: cold miss, hit, prefetch, conflict,
// invalidate mid-fill and reset mid-fill, with hand-computed expectations.
module tb_if_icache_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        inv_i;
  logic [31:0] inst_o, pc_o, hit_cnt, miss_cnt;
  logic        stall_if;
  int unsigned total = 0;
  int unsigned fails = 0;

  if_icache_fetch_if #(.ADDR_W(32), .INST_W(32)) mem_bus ();

  if_icache_fetch #(.ADDR_W(32), .INST_W(32), .INDEX_W(8), .PREFETCH(1)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .inv_i(inv_i), .mem(mem_bus),
    .inst_o(inst_o), .pc_o(pc_o), .stall_if(stall_if),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pc_i = 32'h100; inv_i = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_stall", stall_if, 0);
    chk("rst_req", mem_bus.mem_req, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);

    // Cold miss at 0x100, memory answers 3 cycles after the request rises
    next(); rst_n = 1'b1;
    settle();
    chk("cold_stall_t0", stall_if, 1);
    chk("cold_req_t0", mem_bus.mem_req, 0);
    next(); settle();
    chk("cold_req_t1", mem_bus.mem_req, 1);
    chk("cold_addr_t1", mem_bus.mem_addr, 32'h100);
    chk("cold_stall_t1", stall_if, 1);
    chk("cold_miss_cnt", miss_cnt, 1);
    for (int i = 2; i < 4; i++) begin
      next(); settle();
      chk("cold_stall_wait", stall_if, 1);
      chk("cold_req_held", mem_bus.mem_req, 1);
    end
    next(); mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'h00500093;
    settle();
    chk("cold_fwd_stall", stall_if, 0);
    chk("cold_fwd_inst", inst_o, 32'h00500093);
    chk("cold_fwd_pc", pc_o, 32'h100);

    // Re-fetch hits; prefetch of 0x104 is issued in parallel
    next(); mem_bus.mem_ack = 1'b0; mem_bus.mem_data = '0;
    settle();
    chk("hit_stall", stall_if, 0);
    chk("hit_inst", inst_o, 32'h00500093);
    chk("hit_pc", pc_o, 32'h100);
    chk("pref_req", mem_bus.mem_req, 1);
    chk("pref_addr", mem_bus.mem_addr, 32'h104);
    chk("hit_cnt_before", hit_cnt, 0);
    next(); mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'h00A00113;
    settle();
    chk("hit_cnt_1", hit_cnt, 1);
    chk("hit_during_pref_ack", stall_if, 0);
    next(); mem_bus.mem_ack = 1'b0; pc_i = 32'h104;
    settle();
    chk("pref_hit_stall", stall_if, 0);
    chk("pref_hit_inst", inst_o, 32'h00A00113);
    chk("pref_hit_noreq", mem_bus.mem_req, 0);
    chk("hit_cnt_2", hit_cnt, 2);
    next(); settle();
    chk("hit_cnt_3", hit_cnt, 3);
    chk("miss_cnt_still1", miss_cnt, 1);

    // Conflict: 0x000 and 0x400 share index 0
    next(); pc_i = 32'h000;
    settle();
    chk("c0_stall", stall_if, 1);
    next(); mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'h11111111;
    settle();
    chk("c0_addr", mem_bus.mem_addr, 32'h000);
    chk("c0_inst", inst_o, 32'h11111111);
    chk("c0_miss_cnt", miss_cnt, 2);
    next(); mem_bus.mem_ack = 1'b0;
    settle();
    chk("c0_pref_addr", mem_bus.mem_addr, 32'h004);
    chk("c0_hit", stall_if, 0);
    next(); mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'h22222222;
    settle();
    next(); mem_bus.mem_ack = 1'b0; pc_i = 32'h400;
    settle();
    chk("c4_stall", stall_if, 1);
    chk("c4_req_idle", mem_bus.mem_req, 0);
    next(); mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'h33333333;
    settle();
    chk("c4_addr", mem_bus.mem_addr, 32'h400);
    chk("c4_inst", inst_o, 32'h33333333);
    chk("c4_miss_cnt", miss_cnt, 3);
    next(); mem_bus.mem_ack = 1'b0;
    settle();
    chk("c4_pref_addr", mem_bus.mem_addr, 32'h404);
    next(); mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'h44444444;
    settle();
    next(); mem_bus.mem_ack = 1'b0; pc_i = 32'h000;
    settle();
    chk("c0_again_stall", stall_if, 1);
    next(); mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'h11111111;
    settle();
    chk("c0_again_addr", mem_bus.mem_addr, 32'h000);
    chk("c0_again_miss_cnt", miss_cnt, 4);
    next(); mem_bus.mem_ack = 1'b0;
    settle();
    chk("c0_again_pref", mem_bus.mem_addr, 32'h004);
    next(); mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'h22222222;
    settle();

    // Invalidate while the 0x200 fill is pending
    next(); mem_bus.mem_ack = 1'b0; pc_i = 32'h200;
    settle();
    chk("inv_miss_stall", stall_if, 1);
    next(); inv_i = 1'b1;
    settle();
    chk("inv_req", mem_bus.mem_req, 1);
    chk("inv_addr", mem_bus.mem_addr, 32'h200);
    chk("inv_miss_cnt", miss_cnt, 5);
    next(); inv_i = 1'b0; mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'hDEADBEEF;
    settle();
    chk("drop_stall", stall_if, 1);
    chk("drop_inst", inst_o, 0);
    next(); mem_bus.mem_ack = 1'b0;
    settle();
    chk("drop_idle_req", mem_bus.mem_req, 0);
    chk("drop_not_written", stall_if, 1);
    next(); mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'h55555555;
    settle();
    chk("reissue_addr", mem_bus.mem_addr, 32'h200);
    chk("reissue_miss_cnt", miss_cnt, 6);
    chk("reissue_inst", inst_o, 32'h55555555);
    next(); mem_bus.mem_ack = 1'b0;
    settle();
    chk("reissue_pref", mem_bus.mem_addr, 32'h204);
    next(); mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'h66666666;
    settle();
    next(); mem_bus.mem_ack = 1'b0; pc_i = 32'h100;
    settle();
    chk("inv_cleared_100", stall_if, 1);

    // Reset in the middle of the 0x100 fill
    next(); settle();
    chk("rfill_req", mem_bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_req", mem_bus.mem_req, 0);
    chk("rmid_addr", mem_bus.mem_addr, 0);
    chk("rmid_stall", stall_if, 0);
    chk("rmid_inst", inst_o, 0);
    chk("rmid_pc", pc_o, 0);
    chk("rmid_miss_cnt", miss_cnt, 0);
    chk("rmid_hit_cnt", hit_cnt, 0);
    next(); rst_n = 1'b1; pc_i = 32'h000;
    settle();
    chk("post_rst_miss", stall_if, 1);
    next(); settle();
    chk("post_rst_req", mem_bus.mem_req, 1);
    chk("post_rst_addr", mem_bus.mem_addr, 32'h000);
    chk("post_rst_miss_cnt", miss_cnt, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/if_icache_fetch.md
# if_icache_fetch

Parametrised instruction-fetch stage with a direct-mapped instruction cache, a miss-refill FSM with a request/acknowledge memory handshake, optional next-line prefetch, whole-cache invalidate, and hit/miss performance counters. It sits between the PC register and the decode stage. It returns a cached instruction in the same cycle on a hit, and asserts `stall_if` until a missed word arrives from the memory controller.

## Interface
- `ADDR_W`, 32, PC and memory address width.
- `INST_W`, 32, instruction word width.
- `INDEX_W`, 8, index bits; cache depth = 2^INDEX_W words; tag = pc[ADDR_W-1 : INDEX_W+2].
- `PREFETCH`, 1, 1 enables next-line prefetch after a demand fill; 0 disables it.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `pc_i`  in  ADDR_W  fetch address; bits [1:0] are ignored.
- `inv_i`  in  1  one-cycle pulse that invalidates the whole cache.
- `mem_req`  out  1  refill request, held high until `mem_ack`.
- `mem_addr`  out  ADDR_W  word-aligned refill address, stable while `mem_req` is high.
- `mem_ack`  in  1  one-cycle pulse; `mem_data` is valid in that cycle.
- `mem_data`  in  INST_W  returned instruction word.
- `inst_o`  out  INST_W  fetched instruction; 0 when not valid.
- `pc_o`  out  ADDR_W  PC of `inst_o`; 0 when not valid.
- `stall_if`  out  1  1 means no valid instruction this cycle.
- `hit_cnt`, `miss_cnt`  out  32  free-running counters; wrap at 2^32.

## Operation
- Storage: per entry a valid bit, a tag and a data word. Index = pc[INDEX_W+1:2]. A hit requires valid=1 and a tag match.
- Output priority (combinational):
  1. `rst_n` low: all outputs 0.
  2. Hit: `inst_o` = cached word, `pc_o` = pc_i, `stall_if` = 0.
  3. `mem_ack` high, `mem_addr` == aligned pc_i, and no drop flag: forward `mem_data`, `stall_if` = 0.
  4. Otherwise `stall_if` = 1.
- FSM states: IDLE, FILL, PREF.
  - IDLE: a miss on pc_i moves to FILL with `mem_addr` = {pc_i[ADDR_W-1:2],2'b00} and `mem_req` = 1.
  - FILL: on `mem_ack`, write the entry and drop `mem_req`. Go to PREF with `mem_addr` + 4 and `mem_req` = 1 if PREFETCH=1 and that address misses; otherwise go to IDLE.
  - PREF: on `mem_ack`, write the entry and go to IDLE. A new demand miss during PREF is not issued until PREF completes; the in-flight request is never cancelled.
- Invalidate: `inv_i` clears all valid bits at the next edge. If a request is in flight, a drop flag is set; the returning word is neither written nor forwarded, and the FSM goes to IDLE on `mem_ack`. The drop flag clears on that `mem_ack`.
- If `inv_i` and `mem_ack` arrive in the same cycle, invalidate wins: no write and no forward.
- A fill write and a hit read on the same index in the same cycle: the read sees the old contents; the new entry is visible from the next cycle.
- Counters:
  - `hit_cnt` increments each cycle with a cache hit (priority 2).
  - `miss_cnt` increments once per demand FILL entry. Prefetches are not counted.
  - Both wrap modulo 2^32.

## Timing
- Reset (async assert, sync release): state IDLE, all valid bits 0, `mem_req` 0, `mem_addr` 0, drop flag 0, counters 0.
- Hit latency: 0 cycles, combinational from `pc_i`.
- Miss sequence:
  - Miss seen in cycle t.
  - `mem_req` rises at t+1.
  - Instruction is forwarded in the `mem_ack` cycle.
  - Penalty = 1 + memory latency cycles.
- Prefetch: `mem_req` for the next line rises in the cycle after the demand `mem_ack`. If pc_i reaches that address during PREF, it stalls and is forwarded on `mem_ack`.
- `mem_req` never drops without `mem_ack`, except on `rst_n` assertion.
- `mem_ack` while `mem_req` = 0 is ignored.

## Test plan
- Cold miss, memory latency 3: pc_i=0x100. `stall_if`=1 for 4 cycles. `mem_addr`=0x100. On `mem_ack` with data 0x00500093: `inst_o`=0x00500093, `pc_o`=0x100. `miss_cnt`=1.
- Re-fetch 0x100 after the fill: 0-cycle hit, `hit_cnt` increments, no `mem_req`.
- PREFETCH=1: after the 0x100 fill, `mem_req` rises with `mem_addr`=0x104. Then pc_i=0x104 hits without a further request.
- Conflict, INDEX_W=8: fill 0x000, then fetch 0x400. The second access misses and replaces the entry; fetching 0x000 again misses.
- Invalidate mid-fill: assert `inv_i` while the 0x200 request is pending. The ack data is not forwarded or written, the FSM returns to IDLE, and 0x200 re-issues as a new miss.
- Reset mid-FILL: drive `rst_n` low. `mem_req` and all outputs go to 0 immediately; after release, earlier entries miss.
